vga_timing_generator: RTL and testbench



---
 rtl/vga_timing_generator.sv | 93 +++++++++
 tb/tb_vga_timing_generator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generator.sv
// VGA raster timing generator: horizontal/vertical pixel counters with registered
// sync, blanking and line/frame markers, all decoded from the next-state counters.
module vga_timing_generator #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic             clk_25MHz,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_end,
    output logic             frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Half-open range test [lo, hi_excl)
    function automatic logic in_range(input logic [CNT_W-1:0] c,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi_excl);
        return (c >= lo) && (c < hi_excl);
    endfunction

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             hsync_next;
    logic             vsync_next;
    logic             video_on_next;
    logic             line_end_next;
    logic             frame_end_next;

    always_comb begin
        h_next = h_count + CNT_W'(1);
        v_next = v_count;
        if (h_count == H_LAST) begin
            h_next = '0;
            v_next = (v_count == V_LAST) ? '0 : v_count + CNT_W'(1);
        end
    end

    // Decode from the next-state counters so outputs line up with h_count/v_count
    always_comb begin
        hsync_next     = in_range(h_next, H_SYNC_START, H_SYNC_END) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_next     = in_range(v_next, V_SYNC_START, V_SYNC_END) ? V_SYNC_POL : ~V_SYNC_POL;
        video_on_next  = (h_next < H_ACT_END) && (v_next < V_ACT_END);
        line_end_next  = (h_next == H_LAST);
        frame_end_next = (h_next == H_LAST) && (v_next == V_LAST);
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            h_count   <= '0;
            v_count   <= '0;
            hsync     <= ~H_SYNC_POL;
            vsync     <= ~V_SYNC_POL;
            video_on  <= 1'b1;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
        end else if (pix_en) begin
            h_count   <= h_next;
            v_count   <= v_next;
            hsync     <= hsync_next;
            vsync     <= vsync_next;
            video_on  <= video_on_next;
            line_end  <= line_end_next;
            frame_end <= frame_end_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a default 640x480 instance and a tiny positive-polarity
// instance, both compared every cycle against a frame-index raster model.
module tb_vga_timing_generator;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst_n_a, pix_en_a, rst_n_b, pix_en_b;
    logic [15:0] h_a, v_a;
    logic [7:0]  h_b, v_b;
    logic        hs_a, vs_a, von_a, le_a, fe_a;
    logic        hs_b, vs_b, von_b, le_b, fe_b;

    vga_timing_generator dut_a (
        .clk_25MHz(clk), .rst_n(rst_n_a), .pix_en(pix_en_a),
        .h_count(h_a), .v_count(v_a), .hsync(hs_a), .vsync(vs_a),
        .video_on(von_a), .line_end(le_a), .frame_end(fe_a)
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(8)
    ) dut_b (
        .clk_25MHz(clk), .rst_n(rst_n_b), .pix_en(pix_en_b),
        .h_count(h_b), .v_count(v_b), .hsync(hs_b), .vsync(vs_b),
        .video_on(von_b), .line_end(le_b), .frame_end(fe_b)
    );

    int checks = 0;
    int failures = 0;
    int idx_a = 0;
    int idx_b = 0;
    localparam int FRAME_A = 800 * 525;
    localparam int FRAME_B = 14 * 7;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference raster: position is a linear index into the frame
    task automatic check_raster(input string n, input int idx,
                                input int ha, input int hf, input int hsw, input int hb,
                                input int va, input int vf, input int vsw, input int vb,
                                input bit ph, input bit pv,
                                input logic [31:0] h, input logic [31:0] v,
                                input logic hs, input logic vs, input logic von,
                                input logic le, input logic fe);
        int ht, vt, eh, ev;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        eh = idx % ht;
        ev = idx / ht;
        chk({n, ".h_count"}, h, eh);
        chk({n, ".v_count"}, v, ev);
        chk({n, ".hsync"}, 32'(hs), 32'((eh >= ha + hf && eh < ha + hf + hsw) ? ph : !ph));
        chk({n, ".vsync"}, 32'(vs), 32'((ev >= va + vf && ev < va + vf + vsw) ? pv : !pv));
        chk({n, ".video_on"}, 32'(von), 32'(eh < ha && ev < va));
        chk({n, ".line_end"}, 32'(le), 32'(eh == ht - 1));
        chk({n, ".frame_end"}, 32'(fe), 32'(eh == ht - 1 && ev == vt - 1));
    endtask

    task automatic check_a();
        check_raster("A", idx_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
                     32'(h_a), 32'(v_a), hs_a, vs_a, von_a, le_a, fe_a);
    endtask

    task automatic check_b();
        check_raster("B", idx_b, 8, 2, 3, 1, 4, 1, 1, 1, 1'b1, 1'b1,
                     32'(h_b), 32'(v_b), hs_b, vs_b, von_b, le_b, fe_b);
    endtask

    // One clock: drive enables at the falling edge, advance model, check at next falling edge
    task automatic step(input bit ea, input bit eb);
        pix_en_a = ea;
        pix_en_b = eb;
        @(posedge clk);
        if (ea && rst_n_a) idx_a = (idx_a + 1) % FRAME_A;
        if (eb && rst_n_b) idx_b = (idx_b + 1) % FRAME_B;
        @(negedge clk);
        check_a();
        check_b();
    endtask

    initial begin
        int hs_low, von_cnt, le_cnt, hmin, hmax, le_run;
        int hs_hi_b, vs_hi_b, fe_cnt_b, cyc, last_fe, nper;
        bit ea;

        rst_n_a = 1'b0; rst_n_b = 1'b0; pix_en_a = 1'b0; pix_en_b = 1'b0;
        repeat (3) @(negedge clk);
        check_a();
        check_b();
        rst_n_a = 1'b1; rst_n_b = 1'b1;

        // A: one full line at continuous enable
        hs_low = 0; von_cnt = 0; le_cnt = 0; hmin = 9999; hmax = -1;
        for (int i = 0; i < 800; i++) begin
            if (hs_a === 1'b0) begin
                hs_low++;
                if (int'(h_a) < hmin) hmin = int'(h_a);
                if (int'(h_a) > hmax) hmax = int'(h_a);
            end
            if (von_a === 1'b1) von_cnt++;
            if (le_a === 1'b1) le_cnt++;
            step(1'b1, 1'b0);
        end
        chk("A.hsync_low_cycles", hs_low, 96);
        chk("A.hsync_first", hmin, 656);
        chk("A.hsync_last", hmax, 751);
        chk("A.video_on_cycles", von_cnt, 640);
        chk("A.line_end_cycles", le_cnt, 1);
        chk("A.wrap_h", 32'(h_a), 0);
        chk("A.wrap_v", 32'(v_a), 1);

        // A: enable toggling 1/0 through the end of line 1
        le_run = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'b1, 1'b0);
            if (le_a === 1'b1) le_run++;
            step(1'b0, 1'b0);
            if (le_a === 1'b1) le_run++;
        end
        chk("A.line_end_stretch", le_run, 2);
        chk("A.toggle_pos_v", 32'(v_a), 2);

        // A: random enable
        for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 1)), 1'b0);

        // A: asynchronous reset between edges, mid-line
        #5 rst_n_a = 1'b0;
        idx_a = 0;
        #1 check_a();
        step(1'b1, 1'b0);
        rst_n_a = 1'b1;
        step(1'b1, 1'b0);
        chk("A.after_reset_h", 32'(h_a), 1);

        // B: three frames at continuous enable
        hs_hi_b = 0; vs_hi_b = 0; fe_cnt_b = 0; last_fe = -1; nper = 0;
        for (cyc = 0; cyc < 3 * FRAME_B; cyc++) begin
            if (cyc < FRAME_B) begin
                if (hs_b === 1'b1) hs_hi_b++;
                if (vs_b === 1'b1) vs_hi_b++;
                if (fe_b === 1'b1) fe_cnt_b++;
            end
            if (fe_b === 1'b1) begin
                if (last_fe >= 0) begin
                    chk("B.frame_period", cyc - last_fe, FRAME_B);
                    nper++;
                end
                last_fe = cyc;
            end
            step(1'b0, 1'b1);
        end
        chk("B.hsync_high_cycles", hs_hi_b, 3 * 7);
        chk("B.vsync_high_cycles", vs_hi_b, 14);
        chk("B.frame_end_cycles", fe_cnt_b, 1);
        chk("B.period_count", nper, 2);

        // B: random enable, then asynchronous reset mid-frame
        for (int i = 0; i < 300; i++) begin
            ea = 1'($urandom_range(0, 1));
            step(1'b0, ea);
        end
        while (idx_b < 30) step(1'b0, 1'b1);
        #7 rst_n_b = 1'b0;
        idx_b = 0;
        #1 check_b();
        step(1'b0, 1'b1);
        rst_n_b = 1'b1;
        step(1'b0, 1'b1);
        chk("B.after_reset_h", 32'(h_b), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
